// File: rtl/grf_wb_pkg.sv
// Shared constants and the request record for the GRF writeback arbiter.
// Grant encoding doubles as the LastGrant value.
package grf_wb_pkg;
  localparam logic GRANT_PIPE = 1'b0;
  localparam logic GRANT_MD   = 1'b1;
  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;
  localparam int WB_PC_W   = 32;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] waddr;
    logic [WB_DATA_W-1:0] wd;
    logic [WB_PC_W-1:0]   insaddr;
  } wb_req_t;
endpackage

// File: rtl/grf_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; o_gnt is one-hot or zero.
// Bit 0 is the pipeline, bit 1 the mult/div unit.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);
  import grf_wb_pkg::*;

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      // On contention the source that did not win last time goes first.
      2'b11:   o_gnt = (i_last == GRANT_MD) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/grf_wb_arbiter.sv
// Shares the GRF write port between the pipeline writeback and the mult/div unit.
// Registered Grf* outputs are also the pipeline's forwarding source.
module grf_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              PipeValid,
  input  logic [ADDR_W-1:0] PipeWaddr,
  input  logic [DATA_W-1:0] PipeWD,
  input  logic [PC_W-1:0]   PipeInsAddr,
  output logic              PipeReady,
  input  logic              MdValid,
  input  logic [ADDR_W-1:0] MdWaddr,
  input  logic [DATA_W-1:0] MdWD,
  input  logic [PC_W-1:0]   MdInsAddr,
  output logic              MdReady,
  output logic              GrfEn,
  output logic [ADDR_W-1:0] GrfWaddr,
  output logic [DATA_W-1:0] GrfWD,
  output logic [PC_W-1:0]   GrfInsAddr,
  output logic              LastGrant
);
  import grf_wb_pkg::*;

  logic              w_pipe_live;
  logic              w_md_live;
  logic [1:0]        w_gnt;

  logic              r_en;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wd;
  logic [PC_W-1:0]   r_insaddr;
  logic              r_last;

  // Writes to $0 are discarded, so they never enter arbitration.
  assign w_pipe_live = PipeValid && (PipeWaddr != ADDR_W'(REG_ZERO));
  assign w_md_live   = MdValid   && (MdWaddr   != ADDR_W'(REG_ZERO));

  rr_arb2 u_arb (
    .i_req  ({w_md_live, w_pipe_live}),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  assign PipeReady = !Reset && PipeValid && (!w_pipe_live || w_gnt[0]);
  assign MdReady   = !Reset && MdValid   && (!w_md_live   || w_gnt[1]);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_en      <= 1'b0;
      r_waddr   <= '0;
      r_wd      <= '0;
      r_insaddr <= '0;
      r_last    <= GRANT_MD;
    end else if (w_gnt[1]) begin
      r_en      <= 1'b1;
      r_waddr   <= MdWaddr;
      r_wd      <= MdWD;
      r_insaddr <= MdInsAddr;
      r_last    <= GRANT_MD;
    end else if (w_gnt[0]) begin
      r_en      <= 1'b1;
      r_waddr   <= PipeWaddr;
      r_wd      <= PipeWD;
      r_insaddr <= PipeInsAddr;
      r_last    <= GRANT_PIPE;
    end else begin
      r_en      <= 1'b0;
    end
  end

  assign GrfEn      = r_en;
  assign GrfWaddr   = r_waddr;
  assign GrfWD      = r_wd;
  assign GrfInsAddr = r_insaddr;
  assign LastGrant  = r_last;
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: directed vector table, then random traffic
// checked against a rotating-priority reference model and a shadow register file.
module tb_grf_wb_arbiter;
  import grf_wb_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        PipeValid, MdValid;
  logic [4:0]  PipeWaddr, MdWaddr;
  logic [31:0] PipeWD, MdWD, PipeInsAddr, MdInsAddr;
  logic        PipeReady, MdReady;
  logic        GrfEn, LastGrant;
  logic [4:0]  GrfWaddr;
  logic [31:0] GrfWD, GrfInsAddr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] shadow_rf [32];
  logic [31:0] m_rf      [32];

  always #5 Clk = ~Clk;

  grf_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .PC_W(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .PipeValid(PipeValid), .PipeWaddr(PipeWaddr), .PipeWD(PipeWD),
    .PipeInsAddr(PipeInsAddr), .PipeReady(PipeReady),
    .MdValid(MdValid), .MdWaddr(MdWaddr), .MdWD(MdWD),
    .MdInsAddr(MdInsAddr), .MdReady(MdReady),
    .GrfEn(GrfEn), .GrfWaddr(GrfWaddr), .GrfWD(GrfWD),
    .GrfInsAddr(GrfInsAddr), .LastGrant(LastGrant)
  );

  typedef struct {
    bit          rst;
    bit          pv;
    wb_req_t     preq;
    bit          mv;
    wb_req_t     mreq;
    bit          e_pr, e_mr, e_en;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_pc;
    bit          e_last;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(bit rst, bit pv, logic [4:0] pa, logic [31:0] pd, logic [31:0] pp,
                              bit mv, logic [4:0] ma, logic [31:0] md, logic [31:0] mp,
                              bit epr, bit emr, bit een, logic [4:0] ewa, logic [31:0] ewd,
                              logic [31:0] epc, bit elast);
    vec_t v;
    v.rst = rst; v.pv = pv; v.mv = mv;
    v.preq.waddr = pa; v.preq.wd = pd; v.preq.insaddr = pp;
    v.mreq.waddr = ma; v.mreq.wd = md; v.mreq.insaddr = mp;
    v.e_pr = epr; v.e_mr = emr; v.e_en = een; v.e_wa = ewa;
    v.e_wd = ewd; v.e_pc = epc; v.e_last = elast;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One transaction: drive at posedge+1, sample readies at negedge, outputs at next posedge+1.
  task automatic apply(input bit rst, input bit pv, input wb_req_t p, input bit mv, input wb_req_t m,
                       output bit pr, output bit mr);
    Reset = rst; PipeValid = pv; MdValid = mv;
    PipeWaddr = p.waddr; PipeWD = p.wd; PipeInsAddr = p.insaddr;
    MdWaddr = m.waddr; MdWD = m.wd; MdInsAddr = m.insaddr;
    @(negedge Clk);
    pr = PipeReady;
    mr = MdReady;
    @(posedge Clk);
    #1;
    if (GrfEn) shadow_rf[GrfWaddr] = GrfWD;
  endtask

  // Reference model state
  bit          m_en, m_last;
  logic [4:0]  m_wa;
  logic [31:0] m_wd, m_pc;

  task automatic model_step(input bit rst, input bit pv, input wb_req_t p, input bit mv, input wb_req_t m,
                            output bit epr, output bit emr);
    bit      live [2];
    bit      valid [2];
    wb_req_t req [2];
    int      first, win, src;
    valid[0] = pv; valid[1] = mv;
    req[0] = p;    req[1] = m;
    for (int k = 0; k < 2; k++) live[k] = valid[k] && (req[k].waddr != 0);
    // Priority list starts with whichever source did not win last time.
    first = m_last ? 0 : 1;
    win = -1;
    for (int k = 0; k < 2; k++) begin
      src = (first + k) % 2;
      if (win < 0 && live[src]) win = src;
    end
    epr = !rst && pv && (!live[0] || win == 0);
    emr = !rst && mv && (!live[1] || win == 1);
    if (rst) begin
      m_en = 0; m_wa = 0; m_wd = 0; m_pc = 0; m_last = 1;
    end else if (win >= 0) begin
      m_en = 1; m_wa = req[win].waddr; m_wd = req[win].wd; m_pc = req[win].insaddr;
      m_last = (win == 1);
      m_rf[m_wa] = m_wd;
    end else begin
      m_en = 0;
    end
  endtask

  initial begin
    bit pr, mr, epr, emr, p_hold, m_hold, rst;
    bit pv, mv;
    wb_req_t p, m;
    int mism;

    Reset = 1; PipeValid = 0; MdValid = 0;
    PipeWaddr = 0; PipeWD = 0; PipeInsAddr = 0;
    MdWaddr = 0; MdWD = 0; MdInsAddr = 0;
    for (int i = 0; i < 32; i++) begin shadow_rf[i] = 0; m_rf[i] = 0; end
    repeat (2) @(posedge Clk);
    #1;

    vecs[0]  = mk(1, 1,2,'h22,'h1002,    1,3,'h33,'h2003,    0,0, 0,0,0,0,1);
    vecs[1]  = mk(0, 1,8,'h1234,'h3000,  0,0,0,0,            1,0, 1,8,'h1234,'h3000,0);
    vecs[2]  = mk(0, 0,0,0,0,            0,0,0,0,            0,0, 0,8,'h1234,'h3000,0);
    vecs[3]  = mk(1, 0,0,0,0,            0,0,0,0,            0,0, 0,0,0,0,1);
    vecs[4]  = mk(0, 1,2,'h22,'h1002,    1,3,'h33,'h2003,    1,0, 1,2,'h22,'h1002,0);
    vecs[5]  = mk(0, 1,2,'h22,'h1002,    1,3,'h33,'h2003,    0,1, 1,3,'h33,'h2003,1);
    vecs[6]  = mk(0, 1,2,'h22,'h1002,    1,3,'h33,'h2003,    1,0, 1,2,'h22,'h1002,0);
    vecs[7]  = mk(0, 1,2,'h22,'h1002,    1,3,'h33,'h2003,    0,1, 1,3,'h33,'h2003,1);
    vecs[8]  = mk(0, 1,5,'h55,'h1005,    1,0,'hdead,'h2000,  1,1, 1,5,'h55,'h1005,0);
    vecs[9]  = mk(0, 1,9,'hA,'h1009,     1,9,'hB,'h2009,     0,1, 1,9,'hB,'h2009,1);
    vecs[10] = mk(0, 1,9,'hA,'h1009,     0,0,0,0,            1,0, 1,9,'hA,'h1009,0);
    vecs[11] = mk(0, 0,0,0,0,            1,7,'h77,'h2007,    0,1, 1,7,'h77,'h2007,1);
    vecs[12] = mk(0, 1,4,'h44,'h1004,    1,6,'h66,'h2006,    1,0, 1,4,'h44,'h1004,0);
    vecs[13] = mk(1, 1,10,'h100,'h100A,  1,6,'h66,'h2006,    0,0, 0,0,0,0,1);
    vecs[14] = mk(0, 1,10,'h100,'h100A,  1,6,'h66,'h2006,    1,0, 1,10,'h100,'h100A,0);
    vecs[15] = mk(0, 0,0,0,0,            1,6,'h66,'h2006,    0,1, 1,6,'h66,'h2006,1);

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].rst, vecs[i].pv, vecs[i].preq, vecs[i].mv, vecs[i].mreq, pr, mr);
      $display("[TB] vec %0d rst=%0d pv=%0d pa=%0d mv=%0d ma=%0d -> pr=%0d mr=%0d en=%0d wa=%0d wd=%0h last=%0d",
               i, vecs[i].rst, vecs[i].pv, vecs[i].preq.waddr, vecs[i].mv, vecs[i].mreq.waddr,
               pr, mr, GrfEn, GrfWaddr, GrfWD, LastGrant);
      chk($sformatf("vec%0d_pipe_ready", i), 32'(pr), 32'(vecs[i].e_pr));
      chk($sformatf("vec%0d_md_ready", i), 32'(mr), 32'(vecs[i].e_mr));
      chk($sformatf("vec%0d_grf_en", i), 32'(GrfEn), 32'(vecs[i].e_en));
      chk($sformatf("vec%0d_grf_waddr", i), 32'(GrfWaddr), 32'(vecs[i].e_wa));
      chk($sformatf("vec%0d_grf_wd", i), GrfWD, vecs[i].e_wd);
      chk($sformatf("vec%0d_grf_insaddr", i), GrfInsAddr, vecs[i].e_pc);
      chk($sformatf("vec%0d_last_grant", i), 32'(LastGrant), 32'(vecs[i].e_last));
    end
    // Same-destination pair: the later pipe write must be the one left in $9.
    chk("same_dest_reg9", shadow_rf[9], 32'hA);

    // Random traffic with valid/ready hold discipline.
    for (int i = 0; i < 32; i++) begin shadow_rf[i] = 0; m_rf[i] = 0; end
    p_hold = 0; m_hold = 0;
    pv = 0; mv = 0; p = '0; m = '0;
    m_en = 0; m_last = 1; m_wa = 0; m_wd = 0; m_pc = 0;
    for (int i = 0; i < 400; i++) begin
      rst = (i == 0) || ($urandom_range(0, 39) == 0);
      if (!p_hold) begin
        pv = ($urandom_range(0, 3) != 0);
        p.waddr = 5'($urandom_range(0, 7));
        p.wd = $urandom;
        p.insaddr = $urandom;
      end
      if (!m_hold) begin
        mv = ($urandom_range(0, 2) != 0);
        m.waddr = 5'($urandom_range(0, 7));
        m.wd = $urandom;
        m.insaddr = $urandom;
      end
      model_step(rst, pv, p, mv, m, epr, emr);
      apply(rst, pv, p, mv, m, pr, mr);
      $display("[TB] rnd %0d rst=%0d pv=%0d pa=%0d mv=%0d ma=%0d -> pr=%0d mr=%0d en=%0d wa=%0d last=%0d",
               i, rst, pv, p.waddr, mv, m.waddr, pr, mr, GrfEn, GrfWaddr, LastGrant);
      chk($sformatf("rnd%0d_pipe_ready", i), 32'(pr), 32'(epr));
      chk($sformatf("rnd%0d_md_ready", i), 32'(mr), 32'(emr));
      chk($sformatf("rnd%0d_grf_en", i), 32'(GrfEn), 32'(m_en));
      chk($sformatf("rnd%0d_grf_waddr", i), 32'(GrfWaddr), 32'(m_wa));
      chk($sformatf("rnd%0d_grf_wd", i), GrfWD, m_wd);
      chk($sformatf("rnd%0d_grf_insaddr", i), GrfInsAddr, m_pc);
      chk($sformatf("rnd%0d_last_grant", i), 32'(LastGrant), 32'(m_last));
      p_hold = pv && !epr;
      m_hold = mv && !emr;
    end

    mism = 0;
    for (int i = 0; i < 32; i++) if (shadow_rf[i] !== m_rf[i]) mism++;
    chk("regfile_mismatches", 32'(mism), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
